// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the load/store port.
// Data wins over fetch; one transaction is in flight at a time.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic              flush,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stallreq_if,
    output logic              stallreq_mem,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              discard_q, discard_d;
    logic              req_wr_q, req_wr_d;
    logic [1:0]        req_size_q, req_size_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              inst_ok_q, inst_ok_d;
    logic              data_ok_q, data_ok_d;
    logic              busy;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            discard_q    <= 1'b0;
            req_wr_q     <= 1'b0;
            req_size_q   <= 2'd0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            discard_q    <= discard_d;
            req_wr_q     <= req_wr_d;
            req_size_q   <= req_size_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        discard_d    = discard_q;
        req_wr_d     = req_wr_q;
        req_size_d   = req_size_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        data_addr_ok = 1'b0;
        inst_addr_ok = 1'b0;

        case (state_q)
            IDLE: begin
                discard_d = 1'b0;
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    owner_d      = OWN_DATA;
                    req_wr_d     = data_wr;
                    req_size_d   = data_size;
                    req_addr_d   = data_addr;
                    req_wdata_d  = data_wdata;
                    state_d      = ADDR;
                end else if (inst_req && !flush) begin
                    inst_addr_ok = 1'b1;
                    owner_d      = OWN_INST;
                    req_wr_d     = 1'b0;
                    req_size_d   = 2'd2;
                    req_addr_d   = inst_addr;
                    req_wdata_d  = '0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) state_d = DATA;
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                    if (owner_q == OWN_DATA) begin
                        data_ok_d = 1'b1;
                        if (!req_wr_q) data_rdata_d = bus_rdata;
                    end else if (!discard_q && !flush) begin
                        // A flush landing on the completion cycle also kills the fetch.
                        inst_ok_d    = 1'b1;
                        inst_rdata_d = bus_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && owner_q == OWN_INST && flush) discard_d = 1'b1;
        if (state_d == IDLE) discard_d = 1'b0;
    end

    assign busy         = (state_q != IDLE);
    assign bus_req      = (state_q == ADDR);
    assign bus_wr       = req_wr_q;
    assign bus_size     = req_size_q;
    assign bus_addr     = req_addr_q;
    assign bus_wdata    = req_wdata_q;
    assign inst_data_ok = inst_ok_q;
    assign data_data_ok = data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign dbg_state_o  = state_q;

    assign stallreq_mem = (data_req & ~data_addr_ok) | (busy & (owner_q == OWN_DATA));
    assign stallreq_if  = (inst_req & ~inst_addr_ok) |
                          (busy & (owner_q == OWN_INST) & ~discard_q);

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the CPU's single SRAM-like memory bus between the instruction-fetch port and the data (load/store) port of the MiniMIPS32 core. Data accesses win over fetches, one transaction is outstanding at a time, and completion is routed back to the issuing requester. The block also produces the fetch and memory-stage stall requests that drive the stall bus feeding the pipeline registers, including `stall[3]` of the EXE/MEM register.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width

- `cpu_clk_50M`  in  1  clock
- `cpu_rst`  in  1  synchronous, active-high reset
- `flush`  in  1  pipeline flush (exception/eret)
- `inst_req`  in  1  fetch request; held until `inst_addr_ok`
- `inst_addr`  in  ADDR_W  fetch address
- `inst_addr_ok`  out  1  fetch request accepted (combinational)
- `inst_data_ok`  out  1  fetch data valid (registered pulse)
- `inst_rdata`  out  DATA_W  fetched word
- `data_req`  in  1  data request; held until `data_addr_ok`
- `data_wr`  in  1  1 = store
- `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `data_addr`  in  ADDR_W  data address
- `data_wdata`  in  DATA_W  store data
- `data_addr_ok`  out  1  data request accepted (combinational)
- `data_data_ok`  out  1  load data valid / store done (registered pulse)
- `data_rdata`  out  DATA_W  load data
- `bus_req`  out  1  bus request
- `bus_wr`  out  1  bus write
- `bus_size`  out  2  bus size
- `bus_addr`  out  ADDR_W  bus address
- `bus_wdata`  out  DATA_W  bus write data
- `bus_addr_ok`  in  1  bus accepted address
- `bus_data_ok`  in  1  bus returned data / write done
- `bus_rdata`  in  DATA_W  bus read data
- `stallreq_if`  out  1  fetch stall request (combinational)
- `stallreq_mem`  out  1  memory-stage stall request (combinational)

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: `owner` (0 = INST, 1 = DATA), `discard`, and latched `req_wr`/`req_size`/`req_addr`/`req_wdata`.
- **Grant (IDLE only):**
  - If `data_req`: `data_addr_ok` = 1. At the edge, latch the data fields, set `owner` = DATA, go to ADDR.
  - Else if `inst_req` and not `flush`: `inst_addr_ok` = 1. At the edge, latch `inst_addr` with wr = 0 and size = 2, set `owner` = INST, go to ADDR.
  - Otherwise stay in IDLE.
  - Both `*_addr_ok` are 0 outside IDLE.
- **ADDR:** `bus_req` = 1; `bus_*` are driven from the latched registers. When `bus_addr_ok` = 1, go to DATA. The request is never withdrawn before `bus_addr_ok`.
- **DATA:** `bus_req` = 0. When `bus_data_ok` = 1:
  - Register `bus_rdata` into the owner's rdata.
  - Pulse the owner's `*_data_ok` in the next cycle.
  - Go to IDLE.
- **Flush:**
  - `flush` while `owner` = INST in ADDR or DATA sets `discard`. The bus transaction completes normally, `inst_data_ok` is suppressed, and `inst_rdata` is not updated. `discard` clears on return to IDLE.
  - Data transactions are unaffected by `flush`.
- **Stall requests:**
  - `stallreq_mem` = (`data_req` & ~`data_addr_ok`) | (state ≠ IDLE & `owner` = DATA).
  - `stallreq_if` = (`inst_req` & ~`inst_addr_ok`) | (state ≠ IDLE & `owner` = INST & ~`discard`).
- **Stores:** `data_rdata` is unchanged; `data_data_ok` still pulses.
- `data_rdata` and `inst_rdata` hold their value until the next completion for that port.

## Timing
- **Reset:** synchronous. All outputs and registers go to 0 and the FSM to IDLE, including mid-transaction: `bus_req` drops in the cycle after the reset edge and any in-flight response is ignored.
- **Minimum latency:**
  - Cycle 0: accept (`*_addr_ok` = 1).
  - Cycle 1: ADDR, with `bus_addr_ok` = 1.
  - Cycle 2: DATA, with `bus_data_ok` = 1.
  - Cycle 3: `*_data_ok` = 1 with valid rdata.
- A new grant can occur in cycle 3, the same cycle as the previous `*_data_ok`.
- Bus wait states extend ADDR or DATA indefinitely; there is no timeout.
- `bus_data_ok` outside DATA is ignored.
- Simultaneous `data_req` and `inst_req` in IDLE: data is granted. The fetch waits with `stallreq_if` = 1.

## Test plan
- **Single load:** `data_req` = 1, `data_addr` = 0x80001000, size 2. Bus gives `addr_ok` at cycle 1 and `data_ok` with 0xDEADBEEF at cycle 2. Required: `data_addr_ok` at cycle 0, `bus_req` only in cycle 1, `data_data_ok` = 1 with `data_rdata` = 0xDEADBEEF at cycle 3, `stallreq_mem` = 1 in cycles 1–2.
- **Priority:** `inst_req` and `data_req` both high in IDLE. Required: the data transaction runs first, then the fetch is granted the cycle `data_data_ok` pulses, and each requester receives its own rdata.
- **Flush during fetch:** fetch of 0xBFC00000 accepted, `flush` pulses while in DATA, bus returns 0x12345678. Required: no `inst_data_ok`, `inst_rdata` unchanged, `stallreq_if` = 0 after the flush, IDLE after `bus_data_ok`.
- **Store with wait states:** `data_wr` = 1, size 0, wdata 0xA5. `bus_addr_ok` is delayed 3 cycles and `bus_data_ok` 2 cycles. Required: `bus_*` stable throughout ADDR, `data_data_ok` pulses once, `data_rdata` unchanged.
- **Reset mid-transaction:** `cpu_rst` asserted while in DATA. Required: all outputs 0 and IDLE next cycle, and a following `bus_data_ok` produces no `*_data_ok`.
